// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding, error data word,
// and the request legality rule.
package dm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dm_state_t;

   localparam logic [31:0] DM_ERR_DATA = 32'h0000_0000;

   // A request is illegal when it addresses beyond the array or asks for load and store at once.
   function automatic logic dm_illegal(input logic [31:0] addr, input logic rd, input logic wr,
                                       input int unsigned abits);
      dm_illegal = ((addr >> abits) != 32'd0) || (rd && wr);
   endfunction

endpackage

// File: rtl/dm_sram_array.sv
// Single-port word array with synchronous write and a registered read port that can also be
// cleared to the error data word.
module dm_sram_array
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned DATA_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 we,
   input  logic                 clr,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [DATA_W-1:0]    wdata,
   output logic [DATA_W-1:0]    rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] rdata_r;

   // Array storage; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (en && we && !clr) begin
         mem_r[addr] <= wdata;
      end
   end

   // Read register: loads on a read, zeroes on an error, holds across stores.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= DATA_W'(DM_ERR_DATA);
      end else if (en) begin
         if (clr) begin
            rdata_r <= DATA_W'(DM_ERR_DATA);
         end else if (!we) begin
            rdata_r <= mem_r[addr];
         end else begin
            rdata_r <= rdata_r;
         end
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_STATES cycles, then
// answers with a one-cycle MemReady (and MemError for illegal requests).
module data_memory_responder
   import dm_pkg::*;
#(
   parameter int unsigned ADDR_BITS   = 8,
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned DATA_W      = 32
) (
   input  logic              clk,
   input  logic              Reset_n,
   input  logic [31:0]       Address_DataMem,
   input  logic [DATA_W-1:0] WriteData_DataMem,
   input  logic              MemRead,
   input  logic              MemWrite,
   output logic [DATA_W-1:0] ReadData_DataMem,
   output logic              MemReady,
   output logic              MemError
);

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

   dm_state_t              state_r;
   logic [3:0]             cnt_r;
   logic [ADDR_BITS-1:0]   addr_r;
   logic [DATA_W-1:0]      wdata_r;
   logic                   is_wr_r;
   logic                   err_r;
   logic                   ready_r;
   logic                   error_r;

   logic                   req_s;
   logic                   illegal_s;
   logic                   sram_en_s;
   logic                   sram_we_s;
   logic                   sram_clr_s;
   logic [ADDR_BITS-1:0]   sram_addr_s;
   logic [DATA_W-1:0]      sram_wdata_s;

   // Array port steering: live inputs when a zero-wait request is accepted, latched ones otherwise.
   always_comb begin
      req_s        = MemRead | MemWrite;
      illegal_s    = dm_illegal(Address_DataMem, MemRead, MemWrite, ADDR_BITS);
      sram_en_s    = 1'b0;
      sram_we_s    = 1'b0;
      sram_clr_s   = 1'b0;
      sram_addr_s  = addr_r;
      sram_wdata_s = wdata_r;
      if (state_r == IDLE) begin
         sram_addr_s  = Address_DataMem[ADDR_BITS-1:0];
         sram_wdata_s = WriteData_DataMem;
         sram_we_s    = MemWrite & ~illegal_s;
         sram_clr_s   = illegal_s;
         sram_en_s    = req_s && (WAIT_STATES == 0);
      end else begin
         sram_we_s    = is_wr_r & ~err_r;
         sram_clr_s   = err_r;
         sram_en_s    = (state_r == WAIT) && (cnt_r == WAIT_CNT);
      end
   end

   // Request FSM with wait counter and registered handshake outputs.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
         addr_r  <= '0;
         wdata_r <= '0;
         is_wr_r <= 1'b0;
         err_r   <= 1'b0;
         ready_r <= 1'b0;
         error_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               ready_r <= 1'b0;
               error_r <= 1'b0;
               if (req_s) begin
                  addr_r  <= Address_DataMem[ADDR_BITS-1:0];
                  wdata_r <= WriteData_DataMem;
                  is_wr_r <= MemWrite;
                  err_r   <= illegal_s;
                  if (WAIT_STATES == 0) begin
                     state_r <= RESP;
                     ready_r <= 1'b1;
                     error_r <= illegal_s;
                  end else begin
                     state_r <= WAIT;
                     cnt_r   <= 4'd1;
                  end
               end
            end
            WAIT: begin
               if (cnt_r == WAIT_CNT) begin
                  state_r <= RESP;
                  cnt_r   <= 4'd0;
                  ready_r <= 1'b1;
                  error_r <= err_r;
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            RESP: begin
               state_r <= IDLE;
               ready_r <= 1'b0;
               error_r <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= 4'd0;
               ready_r <= 1'b0;
               error_r <= 1'b0;
            end
         endcase
      end
   end

   dm_sram_array #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_W    (DATA_W)
   ) u_sram (
      .clk   (clk),
      .rst_n (Reset_n),
      .en    (sram_en_s),
      .we    (sram_we_s),
      .clr   (sram_clr_s),
      .addr  (sram_addr_s),
      .wdata (sram_wdata_s),
      .rdata (ReadData_DataMem)
   );

   assign MemReady = ready_r;
   assign MemError = error_r;

endmodule
